// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: op codes (also used by the
// decoder) and the sequencer state encoding.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Iterative datapath: one shift-add multiply step or one restoring-divide
// step per cycle on unsigned magnitudes. hi/lo hold the partial results.
module muldiv_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [WIDTH:0]   sum, shifted, diff;

    // Next partial values: load operands, or advance one multiply/divide step.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        if (load_i) begin
            hi_d = '0;
            lo_d = a_i;
            b_d  = b_i;
        end else if (step_i) begin
            if (div_i) begin
                // A clear sign bit on the trial difference means the divisor fits.
                if (!diff[WIDTH]) begin
                    hi_d = diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shifted[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    // Partial-result registers.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; these are always loaded on accept before use, and HI/LO only copy them from FIX.
        hi_q <= hi_d;
        lo_q <= lo_d;
        b_q  <= b_d;
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_seq.sv
// MIPS-style sequential multiply/divide unit: FSM, iteration counter,
// sign handling and the architectural HI/LO registers.
module muldiv_seq
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_val_i,
    input  logic [WIDTH-1:0] rt_val_i,
    input  logic             read_req_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic             dz_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d, op_in;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d, dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] mag_a, mag_b, dp_hi, dp_lo, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;
    logic             accept, div_zero, last_step, in_signed;

    assign op_in     = md_op_e'(op_i);
    assign in_signed = op_is_signed(op_in);
    assign accept    = (state_q == ST_IDLE || state_q == ST_DONE) && start_i && !flush_i;
    assign div_zero  = op_is_div(op_in) && (rt_val_i == '0);
    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign mag_a     = (in_signed && rs_val_i[WIDTH-1]) ? -rs_val_i : rs_val_i;
    assign mag_b     = (in_signed && rt_val_i[WIDTH-1]) ? -rt_val_i : rt_val_i;

    muldiv_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .load_i (accept),
        .step_i (state_q == ST_RUN),
        .div_i  (op_is_div(op_q)),
        .a_i    (mag_a),
        .b_i    (mag_b),
        .hi_o   (dp_hi),
        .lo_o   (dp_lo)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush abandons an in-flight operation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) state_d = div_zero ? ST_DONE : ST_RUN;
                else        state_d = ST_IDLE;
            end
            ST_RUN:  state_d = flush_i ? ST_IDLE : (last_step ? ST_FIX : ST_RUN);
            ST_FIX:  state_d = flush_i ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy_o  = (state_q == ST_RUN) || (state_q == ST_FIX);
        done_o  = (state_q == ST_DONE);
        dz_o    = done_o && dz_q;
        stall_o = busy_o && (start_i || read_req_i);
    end

    // Sign correction of the unsigned magnitude result.
    always_comb begin
        prod   = {dp_hi, dp_lo};
        res_hi = dp_hi;
        res_lo = dp_lo;
        if (op_is_div(op_q)) begin
            if (neg_a_q ^ neg_b_q) res_lo = -dp_lo;
            if (neg_a_q)           res_hi = -dp_hi;
        end else if (neg_a_q ^ neg_b_q) begin
            prod             = -{dp_hi, dp_lo};
            {res_hi, res_lo} = prod;
        end
    end

    // Operation context, counter and HI/LO next values.
    always_comb begin
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (accept) begin
            op_d    = op_in;
            neg_a_d = in_signed && rs_val_i[WIDTH-1];
            neg_b_d = in_signed && rt_val_i[WIDTH-1];
            dz_d    = div_zero;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == ST_FIX && !flush_i) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end
    end

    // Context, counter and architectural HI/LO registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            op_q    <= OP_MULT;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, multi-cycle
// corner sequences and randomized operations against an arithmetic model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, start_i, read_req_i, flush_i;
    logic [1:0]  op_i;
    logic [31:0] rs_val_i, rt_val_i;
    logic        busy_o, stall_o, done_o, dz_o;
    logic [31:0] hi_o, lo_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] model_hilo;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .rs_val_i   (rs_val_i),
        .rt_val_i   (rt_val_i),
        .read_req_i (read_req_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .dz_o       (dz_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic; {hi,lo} unchanged on divide by zero.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] prev);
        longint sa, sb, q, rm;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = prev;
        case (op)
            2'b00: r = sa * sb;
            2'b01: r = {32'h0, a} * {32'h0, b};
            2'b10: if (b != 0) begin
                q  = sa / sb;
                rm = sa % sb;
                r  = {rm[31:0], q[31:0]};
            end
            default: if (b != 0) r = {a % b, a / b};
        endcase
        return r;
    endfunction

    // Waits for done_o from cycle 'from'; lat = -1 if it never comes.
    task automatic wait_done(input int from, output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int c = from; c <= 60; c++) begin
            if (busy_o) busy_cnt++;
            if (done_o) begin
                lat = c;
                break;
            end
            tick();
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt);
        start_i  = 1'b1;
        op_i     = op;
        rs_val_i = a;
        rt_val_i = b;
        tick();
        start_i = 1'b0;
        wait_done(1, lat, busy_cnt);
    endtask

    initial begin
        int lat, busy_cnt, seen;
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        logic        r_dz;
        logic [63:0] exp;

        vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
        vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[4] = '{2'b11, 32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022, 1'b0, 34};
        vecs[5] = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000011, 32'h00000022, 1'b1, 1};
        vecs[6] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
        vecs[7] = '{2'b01, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b0, 34};

        rst = 1'b1; start_i = 1'b0; read_req_i = 1'b0; flush_i = 1'b0;
        op_i = 2'b00; rs_val_i = '0; rt_val_i = '0;
        repeat (3) tick();
        check("reset_hi_lo", {hi_o, lo_o}, 64'h0);
        check("reset_flags", 64'({busy_o, stall_o, done_o, dz_o}), 64'h0);
        rst = 1'b0;
        tick();

        // Flush in IDLE only blocks acceptance.
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; rs_val_i = 32'd3; rt_val_i = 32'd3;
        tick();
        start_i = 1'b0; flush_i = 1'b0;
        check("idle_flush_blocks", 64'(busy_o), 64'h0);
        tick();

        // Directed vector table.
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_cnt);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_hi", i), 64'(hi_o), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(lo_o), 64'(vecs[i].lo));
            check($sformatf("vec%0d_dz", i), 64'(dz_o), 64'(vecs[i].dz));
            check($sformatf("vec%0d_busy", i), 64'(busy_cnt), vecs[i].dz ? 64'd0 : 64'd33);
            model_hilo = {vecs[i].hi, vecs[i].lo};
        end

        // start_i + read_req_i mid-run: stall, no restart.
        start_i = 1'b1; op_i = 2'b01; rs_val_i = 32'd6; rt_val_i = 32'd7;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        start_i = 1'b1; read_req_i = 1'b1; rs_val_i = 32'd3; rt_val_i = 32'd3;
        #1;
        check("run_stall", 64'(stall_o), 64'h1);
        tick();
        start_i = 1'b0; read_req_i = 1'b0;
        wait_done(6, lat, busy_cnt);
        check("no_restart_lat", 64'(lat), 64'd34);
        check("no_restart_res", {hi_o, lo_o}, 64'd42);
        read_req_i = 1'b1;
        #1;
        check("done_read_no_stall", 64'(stall_o), 64'h0);
        read_req_i = 1'b0;

        // Flush mid-run of a second op.
        start_i = 1'b1; op_i = 2'b01; rs_val_i = 32'd9; rt_val_i = 32'd9;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_idle", 64'(busy_o), 64'h0);
        seen = 0;
        repeat (40) begin
            if (done_o) seen = 1;
            tick();
        end
        check("flush_no_done", 64'(seen), 64'h0);
        check("flush_hilo_kept", {hi_o, lo_o}, 64'd42);

        // Back-to-back: second start issued in the DONE cycle.
        do_op(2'b01, 32'h1234, 32'h10, lat, busy_cnt);
        check("b2b_first_res", {hi_o, lo_o}, 64'h12340);
        do_op(2'b11, 32'd1000, 32'd7, lat, busy_cnt);
        check("b2b_second_lat", 64'(lat), 64'd34);
        check("b2b_second_res", {hi_o, lo_o}, {32'd6, 32'd142});

        // Reset mid-run, with start_i also high to show reset dominates.
        start_i = 1'b1; op_i = 2'b00; rs_val_i = 32'd77; rt_val_i = 32'd5;
        tick();
        start_i = 1'b0;
        repeat (19) tick();
        rst = 1'b1; start_i = 1'b1; flush_i = 1'b1;
        tick();
        check("rst_mid_hilo", {hi_o, lo_o}, 64'h0);
        check("rst_mid_flags", 64'({busy_o, stall_o, done_o, dz_o}), 64'h0);
        tick();
        check("rst_dominates_start", 64'(busy_o), 64'h0);
        rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        tick();
        check("post_rst_idle", 64'({busy_o, done_o}), 64'h0);
        model_hilo = 64'h0;

        // Randomized operations against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = (n % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            r_b  = ($urandom_range(0, 6) == 0) ? 32'h0 : ((n % 4 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            r_dz = r_op[1] && (r_b == 0);
            exp  = ref_result(r_op, r_a, r_b, model_hilo);
            do_op(r_op, r_a, r_b, lat, busy_cnt);
            check($sformatf("rnd%0d_op%0d_lat", n, r_op), 64'(lat), r_dz ? 64'd1 : 64'd34);
            check($sformatf("rnd%0d_op%0d_%h_%h_res", n, r_op, r_a, r_b), {hi_o, lo_o}, exp);
            check($sformatf("rnd%0d_dz", n), 64'(dz_o), 64'(r_dz));
            model_hilo = exp;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; iteration count equals WIDTH.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start_i  input  1  EX-stage request to begin an operation.
REQ-005 op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i.
REQ-006 rs_val_i  input  WIDTH  multiplicand/dividend; sampled with start_i.
REQ-007 rt_val_i  input  WIDTH  multiplier/divisor; sampled with start_i.
REQ-008 read_req_i  input  1  EX-stage MFHI/MFLO present.
REQ-009 flush_i  input  1  cancel in-flight operation (branch/jump flush).
REQ-010 busy_o  output  1  high in RUN and FIX.
REQ-011 stall_o  output  1  busy_o & (start_i | read_req_i); to hazard unit.
REQ-012 done_o  output  1  one-cycle completion pulse.
REQ-013 dz_o  output  1  divide-by-zero flag, valid only with done_o.
REQ-014 hi_o, lo_o  output  WIDTH each  architectural HI/LO registers.

Function
REQ-015 FSM states SHALL be IDLE, RUN, FIX, DONE.
REQ-016 start_i accepted only in IDLE or DONE with flush_i low; accept captures op, |operands| (signed ops) or raw operands (unsigned ops), and operand signs.
REQ-017 Accept SHALL go to RUN with iteration counter 0, except DIV/DIVU with rt_val_i==0, which SHALL go directly to DONE.
REQ-018 RUN SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per cycle; counter increments; leave RUN to FIX after counter reaches WIDTH-1 (exactly WIDTH RUN cycles).
REQ-019 FIX SHALL apply sign correction (one cycle) and go to DONE; HI/LO updated on the edge entering DONE.
REQ-020 DONE SHALL assert done_o for one cycle; next state RUN on valid start, else IDLE.
REQ-021 Latency: done_o high in cycle WIDTH+2 after accept edge (34 at WIDTH=32); divide-by-zero: cycle 1 after accept.
REQ-022 MULT/MULTU: {hi_o,lo_o} = full 2*WIDTH product; MULT product negated if operand signs differ.
REQ-023 DIV/DIVU: lo_o = quotient truncated toward zero, hi_o = remainder; signed remainder takes dividend sign.
REQ-024 DIV of most-negative by -1 SHALL yield lo_o = most-negative, hi_o = 0 (two's-complement wrap, no trap).
REQ-025 Divide by zero: dz_o=1 with done_o, hi_o/lo_o unchanged.
REQ-026 start_i in RUN/FIX SHALL be ignored (no capture); stall_o holds the requester until DONE.
REQ-027 flush_i in RUN/FIX SHALL return to IDLE next edge, no done_o, hi_o/lo_o unchanged.
REQ-028 flush_i has priority over start_i in the same cycle; flush_i in IDLE/DONE only blocks acceptance.
REQ-029 read_req_i in DONE or IDLE SHALL not stall; hi_o/lo_o already hold the newest result.

Reset
REQ-030 rst high SHALL force IDLE, counter 0, hi_o=lo_o=0, busy_o=stall_o=done_o=dz_o=0 on next edge, including mid-operation (result discarded).
REQ-031 rst SHALL dominate flush_i and start_i.

Structure
REQ-032 Op encodings (MULT/MULTU/DIV/DIVU) and FSM state encoding SHALL live in the shared package mips_pkg, also used by the decoder.
REQ-033 One sub-module muldiv_dp SHALL hold the per-step shift-add/restoring-subtract datapath and partial registers; muldiv_seq holds FSM, counter, sign logic, HI/LO.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done_o at cycle 34, hi_o=0xFFFFFFFE, lo_o=0x00000001, dz_o=0.
REQ-035 MULT -3 x 5 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1; busy_o high cycles 1..33.
REQ-036 DIV -7 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-037 DIVU 100 / 0 with prior hi_o/lo_o=0x11/0x22 -> done_o at cycle 1, dz_o=1, hi_o/lo_o stay 0x11/0x22.
REQ-038 MULTU 6x7 with start_i+read_req_i pulsed at RUN cycle 5 -> stall_o=1 that cycle, no restart; flush_i at RUN cycle 10 of a second op -> IDLE, no done_o, hi_o/lo_o stay 0/42.
REQ-039 Back-to-back: start in DONE cycle -> second op accepted, done_o 34 cycles later; rst at RUN cycle 20 -> all outputs 0 next cycle.
